axi_write_responder: RTL

//  Slave-side AXI write responder for the 64-bit data path (8 byte lanes, 12-bit / 4KB address window).

---
 rtl/axi_pkg.sv | 36 +++
 rtl/axi_wr_addr_gen.sv | 33 +++
 rtl/axi_write_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write-path constants and the byte-lane table used by both
// the master-side byte-enable generator and this responder.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    // Lanes from the byte offset up to the next (1<<size)-aligned boundary;
    // sizes above 3 cover the rest of the 8-byte word.
    function automatic logic [7:0] lane_mask(input logic [2:0] offset, input logic [2:0] size);
        logic [2:0] last;
        logic [7:0] mask;
        if (size >= 3'd3) begin
            last = 3'd7;
        end else begin
            last = offset | ((3'd1 << size) - 3'd1);
        end
        mask = '0;
        for (int b = 0; b < 8; b++) begin
            mask[b] = (3'(b) >= offset) && (3'(b) <= last);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts inside
// the 4KB window.
module axi_wr_addr_gen
    import axi_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] beat_bytes;
    logic [ADDR_W-1:0] aligned;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    // WRAP keeps the upper bits of the (len+1)<<size block and lets only the
    // low bits advance, which is why the start need not be block aligned.
    always_comb begin
        beat_bytes = ADDR_W'(1) << size;
        aligned    = addr & ~(beat_bytes - ADDR_W'(1));
        incr_addr  = aligned + beat_bytes;
        wrap_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_write_responder.sv
// Slave-side AXI write responder: one burst at a time, byte-masked SRAM
// writes, and a single B response per burst.
module axi_write_responder
    import axi_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              mem_we,
    output logic [8:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_be
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        count;
    logic              err;
    logic              suppress;

    logic [ADDR_W-1:0] next_addr;
    logic [STRB_W-1:0] lanes;
    logic [STRB_W-1:0] beat_be;
    logic              last_beat;
    logic              err_next;
    logic              aw_illegal;

    axi_wr_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Illegal bursts still consume their W beats so the master never stalls.
    always_comb begin
        aw_illegal = (awsize > 3'd3) || (awburst == BURST_RSVD) ||
                     ((awburst == BURST_WRAP) &&
                      !((awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15)));
        lanes     = lane_mask(addr_q[2:0], size_q);
        beat_be   = wstrb & lanes;
        last_beat = (count == len_q);
        err_next  = err || (|(wstrb & ~lanes)) || (wlast != last_beat);
    end

    // WLAST is only checked; the beat count alone terminates the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= RESP_OKAY;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            count     <= '0;
            err       <= 1'b0;
            suppress  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (awready && awvalid) begin
                        id_q     <= awid;
                        addr_q   <= awaddr;
                        len_q    <= awlen;
                        size_q   <= awsize;
                        burst_q  <= awburst;
                        count    <= '0;
                        err      <= aw_illegal;
                        suppress <= aw_illegal;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        state    <= ST_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (wvalid && wready) begin
                        mem_be    <= beat_be;
                        mem_we    <= (|beat_be) && !suppress;
                        mem_addr  <= addr_q[11:3];
                        mem_wdata <= wdata;
                        addr_q    <= next_addr;
                        count     <= count + 8'd1;
                        err       <= err_next;
                        if (last_beat) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= err_next ? RESP_SLVERR : RESP_OKAY;
                            state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
